cp0_timer_ctrl: RTL
===================

// Module: cp0_timer_ctrl
// PURPOSE
//   CP0 coprocessor with a configurable number of compare timers and a prescaled Count.
//   Adds interrupt masking/request generation (Status.IM/IE/EXL vs Cause.IP).
//   Sits beside MEM/WB: accepts mtc0/mfc0 accesses and exception/ERET events from the
//   exception stage, and drives flush, the exception target address and int_req to the core.
// PARAMETERS
//   DATA_W      32   register width (Count, Compare, EPC, BadVAddr)
//   NUM_TIMERS  2    compare channels, 1..6; channel k read/written at CP0 reg 11, sel=k
//   CNT_DIV     2    Count increments once every CNT_DIV clocks (>=1)
//   EXC_ADDR    32'h00000100  general exception vector
//   INT_ADDR    32'h00000040  interrupt vector (exccode==EXC_INT)
// PORTS
//   cpu_clk_50M  in   1           clock
//   cpu_rst      in   1           synchronous reset, active-high
//   we / re      in   1           CP0 write / read enable
//   waddr/raddr  in   5           CP0 register number
//   wsel/rsel    in   3           select field (Compare channel index; 0 otherwise)
//   wdata        in   DATA_W      write data
//   data_o       out  DATA_W      read data, combinational; 0 if re=0 or unmapped
//   int_i        in   6           external hardware interrupt lines (level)
//   exccode_i    in   5           EXC_NONE / EXC_ERET / EXC_INT / other exception code
//   pc_i         in   32          PC of excepting instruction
//   in_delay_i   in   1           excepting instruction is in a delay slot
//   badvaddr_i   in   DATA_W      faulting address (used for AdEL/AdES only)
//   flush        out  1           1 when exccode_i != EXC_NONE (0 in reset)
//   cp0_excaddr  out  32          redirect target, combinational
//   status_o     out  32          Status register
//   cause_o      out  32          Cause register
//   timer_int    out  NUM_TIMERS  per-channel sticky pending flags
//   int_req      out  1           Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0])
// BEHAVIOUR
//   Reset: count=0, prescaler=0, all compare=0, armed=0, timer_int=0, epc=0, badvaddr=0,
//     status=32'h1000_0000, cause={25'b0,EXC_NONE,2'b0}; int_req=0, flush=0, excaddr=PC_INIT.
//   Prescaler: counts 0..CNT_DIV-1; tick when value==CNT_DIV-1; Count<=Count+1 on tick,
//     wraps 2^DATA_W-1 -> 0. mtc0 Count loads wdata and clears prescaler; write beats tick.
//   Compare k: mtc0 (11,k) loads compare[k], sets armed[k], clears timer_int[k].
//     timer_int[k] set on the cycle after a tick where Count+1 == compare[k] && armed[k];
//     sticky until next write to compare[k]. Same-cycle write and match: write wins (cleared).
//     Wrap case: Count=FFFF_FFFF, compare=0 -> fires on wrap. mtc0 Count==compare: no fire.
//   Cause.IP[7:2] <= int_i | {|timer_int, 5'b0} (registered, 1-cycle); Cause.TI(30)=|timer_int.
//     Cause.IP[1:0] (bits 9:8) software-writable; other Cause bits read-only.
//   Status writable bits: IM[15:8], EXL[1], IE[0]; all others read-only.
//   Priority per cycle: exception > ERET > mtc0. mtc0 is ignored when exccode_i != EXC_NONE.
//   Exception (not NONE/ERET): if EXL==0 {BD<=in_delay_i; EPC<=in_delay_i ? pc_i-4 : pc_i};
//     EXL<=1; ExcCode<=exccode_i; badvaddr<=badvaddr_i only for AdEL(0x04)/AdES(0x05).
//   ERET: EXL<=0. Target = EPC, or wdata if same-cycle we && waddr==EPC (forward).
//   cp0_excaddr: reset -> PC_INIT; EXC_INT -> INT_ADDR; ERET -> EPC/forward; other -> EXC_ADDR;
//     EXC_NONE -> 0.
//   Read mux: 8 BadVAddr, 9 Count, 11/sel Compare[sel] (sel>=NUM_TIMERS -> 0), 12 Status,
//     13 Cause, 14 EPC; reads return pre-write (registered) value in a same-cycle write.
//   Reset asserted mid-operation: all state returns to reset values on that clock edge.
// TESTING
//   CNT_DIV=2, write Count=10 -> Count reads 10,10,11,11,12 on following cycles.
//   Compare0=20, Count=18, IM[7]=1, IE=1 -> timer_int[0] and Cause.IP7 set; int_req=1
//     one cycle later; write Compare0 -> timer_int[0]=0.
//   Count=FFFF_FFFF, Compare1=0 -> timer_int[1] set after wrap; timer_int[0] untouched.
//   Exception 0x04, pc=0x80, in_delay=1, EXL=0 -> EPC=0x7C, BD=1, EXL=1, badvaddr latched,
//     flush=1, excaddr=EXC_ADDR; second exception with EXL=1 leaves EPC unchanged.
//   ERET + same-cycle mtc0 EPC=0x200 -> excaddr=0x200, EXL=0, EPC not written.
//   mtc0 Status=0xFFFF_FFFF -> reads 0x1000_FF03; rsel=7 on reg 11 -> data_o=0.

Source files
------------

// File: rtl/cp0_timer_ctrl.sv
// CP0 coprocessor: prescaled Count, NUM_TIMERS compare channels with sticky
// pending flags, Status/Cause/EPC/BadVAddr, exception/ERET sequencing and
// interrupt request generation for the core.
module cp0_timer_ctrl #(
  parameter int          DATA_W     = 32,
  parameter int          NUM_TIMERS = 2,
  parameter int          CNT_DIV    = 2,
  parameter logic [31:0] EXC_ADDR   = 32'h0000_0100,
  parameter logic [31:0] INT_ADDR   = 32'h0000_0040,
  parameter logic [31:0] PC_INIT    = 32'hBFC0_0000
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [4:0]            waddr,
  input  logic [4:0]            raddr,
  input  logic [2:0]            wsel,
  input  logic [2:0]            rsel,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     data_o,
  input  logic [5:0]            int_i,
  input  logic [4:0]            exccode_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delay_i,
  input  logic [DATA_W-1:0]     badvaddr_i,
  output logic                  flush,
  output logic [31:0]           cp0_excaddr,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [NUM_TIMERS-1:0] timer_int,
  output logic                  int_req
);

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] STATUS_RST  = 32'h1000_0000;
  // IM[15:8], EXL[1], IE[0]
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam int            PW        = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CNT_DIV - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [DATA_W-1:0]     count_q, count_d;
  logic [DATA_W-1:0]     cmp_q [NUM_TIMERS];
  logic [DATA_W-1:0]     cmp_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] armed_q, armed_d;
  logic [NUM_TIMERS-1:0] tint_q, tint_d;
  logic [DATA_W-1:0]     epc_q, epc_d;
  logic [DATA_W-1:0]     badvaddr_q, badvaddr_d;
  logic [31:0]           status_q, status_d;
  logic [5:0]            ip_hw_q, ip_hw_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic                  bd_q, bd_d;
  logic [4:0]            exccode_q, exccode_d;

  logic              wr_en;
  logic              is_eret;
  logic              is_exc;
  logic              tick;
  logic              cnt_wr;
  logic [DATA_W-1:0] count_inc;

  // Event decode: an exception or ERET in the same cycle suppresses mtc0.
  always_comb begin
    wr_en     = we && (exccode_i == EXC_NONE);
    is_eret   = (exccode_i == EXC_ERET);
    is_exc    = (exccode_i != EXC_NONE) && (exccode_i != EXC_ERET);
    tick      = (presc_q == PRESC_MAX);
    cnt_wr    = wr_en && (waddr == REG_COUNT);
    count_inc = count_q + DATA_W'(1);
  end

  // Prescaler and Count: an mtc0 to Count overrides the tick and restarts the prescaler.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    count_d = tick ? count_inc : count_q;
    if (cnt_wr) begin
      count_d = wdata;
      presc_d = '0;
    end
  end

  // Compare channels: a match is only seen on a real increment; a compare write clears and wins.
  always_comb begin
    armed_d = armed_q;
    tint_d  = tint_q;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      cmp_d[k] = cmp_q[k];
      if (tick && !cnt_wr && armed_q[k] && (count_inc == cmp_q[k]))
        tint_d[k] = 1'b1;
      if (wr_en && (waddr == REG_COMPARE) && (wsel == 3'(k))) begin
        cmp_d[k]   = wdata;
        armed_d[k] = 1'b1;
        tint_d[k]  = 1'b0;
      end
    end
  end

  // Status, Cause, EPC and BadVAddr updates; exception and ERET never coincide with mtc0.
  always_comb begin
    status_d   = status_q;
    ip_hw_d    = int_i | {|tint_q, 5'b0};
    ip_sw_d    = ip_sw_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (wr_en) begin
      case (waddr)
        REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (32'(wdata) & STATUS_WMASK);
        REG_CAUSE:  ip_sw_d  = wdata[9:8];
        REG_EPC:    epc_d    = wdata;
        default:    ;
      endcase
    end
    if (is_exc) begin
      if (!status_q[1]) begin
        bd_d  = in_delay_i;
        epc_d = in_delay_i ? DATA_W'(pc_i - 32'd4) : DATA_W'(pc_i);
      end
      status_d[1] = 1'b1;
      exccode_d   = exccode_i;
      if ((exccode_i == EXC_ADEL) || (exccode_i == EXC_ADES))
        badvaddr_d = badvaddr_i;
    end else if (is_eret) begin
      status_d[1] = 1'b0;
    end
  end

  // State registers; reset returns every field to its power-on value.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      presc_q    <= '0;
      count_q    <= '0;
      for (int k = 0; k < NUM_TIMERS; k++) cmp_q[k] <= '0;
      armed_q    <= '0;
      tint_q     <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      status_q   <= STATUS_RST;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= EXC_NONE;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      for (int k = 0; k < NUM_TIMERS; k++) cmp_q[k] <= cmp_d[k];
      armed_q    <= armed_d;
      tint_q     <= tint_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      status_q   <= status_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
    end
  end

  // Register-derived outputs; Cause.TI reflects the live pending flags.
  always_comb begin
    timer_int = tint_q;
    status_o  = status_q;
    cause_o   = {bd_q, |tint_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
    int_req   = status_q[0] && !status_q[1] && (|(cause_o[15:8] & status_q[15:8]));
  end

  // Flush and redirect target for the core; ERET forwards a same-cycle EPC write.
  always_comb begin
    flush       = !cpu_rst && (exccode_i != EXC_NONE);
    cp0_excaddr = 32'h0;
    if (cpu_rst)
      cp0_excaddr = PC_INIT;
    else if (exccode_i == EXC_NONE)
      cp0_excaddr = 32'h0;
    else if (exccode_i == EXC_INT)
      cp0_excaddr = INT_ADDR;
    else if (is_eret)
      cp0_excaddr = (we && (waddr == REG_EPC)) ? 32'(wdata) : 32'(epc_q);
    else
      cp0_excaddr = EXC_ADDR;
  end

  // Read mux: registered values only, so a same-cycle write is not visible yet.
  always_comb begin
    data_o = '0;
    if (re) begin
      case (raddr)
        REG_BADVADDR: data_o = badvaddr_q;
        REG_COUNT:    data_o = count_q;
        REG_COMPARE: begin
          for (int k = 0; k < NUM_TIMERS; k++)
            if (rsel == 3'(k)) data_o = cmp_q[k];
        end
        REG_STATUS:   data_o = DATA_W'(status_q);
        REG_CAUSE:    data_o = DATA_W'(cause_o);
        REG_EPC:      data_o = epc_q;
        default:      data_o = '0;
      endcase
    end
  end

endmodule
